// File: rtl/seq_pattern_pkg.sv
// rtl/seq_pattern_pkg.sv - shared types and the 13-event pattern table for seq_pattern_gen
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int NUM_EVENTS      = 13;
    localparam int TOTAL_GAP_TICKS = 39;
    localparam logic [3:0] LAST_STEP = 4'd12;

    // sig_id: 0=i1, 1=i2, 2=i3, 3=i4; gap_ticks is the distance to the next event
    typedef struct packed {
        logic [1:0] sig_id;
        logic       value;
        logic [2:0] gap_ticks;
    } event_t;

    localparam event_t EVENT_TABLE [NUM_EVENTS] = '{
        '{2'd2, 1'b1, 3'd5},
        '{2'd0, 1'b1, 3'd2},
        '{2'd2, 1'b0, 3'd1},
        '{2'd3, 1'b1, 3'd3},
        '{2'd0, 1'b0, 3'd5},
        '{2'd1, 1'b1, 3'd5},
        '{2'd0, 1'b1, 3'd5},
        '{2'd3, 1'b0, 3'd3},
        '{2'd2, 1'b1, 3'd3},
        '{2'd3, 1'b1, 3'd2},
        '{2'd1, 1'b0, 3'd2},
        '{2'd0, 1'b0, 3'd3},
        '{2'd2, 1'b0, 3'd0}
    };

    function automatic logic [3:0] apply_event(input logic [3:0] pattern, input event_t ev);
        logic [3:0] result;
        result = pattern;
        result[ev.sig_id] = ev.value;
        return result;
    endfunction

endpackage

// File: rtl/seq_pattern_gen_tick_timer.sv
// rtl/seq_pattern_gen_tick_timer.sv - loadable down-counter that saturates at zero
module tick_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - replays the 13-event i1..i4 pattern on start, then pulses done
module seq_pattern_gen
    import seq_pattern_pkg::*;
#(
    parameter int CYCLES_PER_TICK = 4,
    parameter int HOLD_TICKS      = 2,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       i1,
    output logic       i2,
    output logic       i3,
    output logic       i4,
    output logic       busy,
    output logic       done,
    output logic [3:0] step
);

    localparam logic [CNT_W-1:0] FIRST_LOAD =
        CNT_W'(int'(EVENT_TABLE[0].gap_ticks) * CYCLES_PER_TICK - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS * CYCLES_PER_TICK - 1);
    localparam logic [3:0] FIRST_PATTERN = apply_event(4'b0000, EVENT_TABLE[0]);

    state_e           state_q;
    logic [3:0]       pattern_q;
    logic [3:0]       pattern_d;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       step_q;

    logic [3:0]       next_step;
    event_t           next_ev;
    logic [CNT_W-1:0] next_load;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_expire;

    assign next_step = step_q + 4'd1;
    assign next_ev   = (next_step <= LAST_STEP) ? EVENT_TABLE[next_step] : '0;
    assign next_load = (next_step == LAST_STEP) ? HOLD_LOAD
                     : CNT_W'(int'(next_ev.gap_ticks) * CYCLES_PER_TICK - 1);
    assign pattern_d = apply_event(pattern_q, next_ev);

    // Abort parks the counter at zero so a later start always loads from a clean state.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = FIRST_LOAD;
                end
            end
            RUN: begin
                if (abort) begin
                    tmr_load = 1'b1;
                end else if (tmr_expire) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = next_load;
                end
            end
            HOLD: begin
                if (abort) begin
                    tmr_load = 1'b1;
                end
            end
            default: begin
                tmr_load = 1'b1;
            end
        endcase
    end

    tick_timer #(
        .CNT_W(CNT_W)
    ) u_tick_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            step_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        pattern_q <= FIRST_PATTERN;
                        step_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        pattern_q <= '0;
                        step_q    <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (tmr_expire) begin
                        pattern_q <= pattern_d;
                        step_q    <= next_step;
                        if (next_step == LAST_STEP) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        pattern_q <= '0;
                        step_q    <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (tmr_expire) begin
                        done_q    <= 1'b1;
                        pattern_q <= '0;
                        step_q    <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    pattern_q <= '0;
                    step_q    <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign i1   = pattern_q[0];
    assign i2   = pattern_q[1];
    assign i3   = pattern_q[2];
    assign i4   = pattern_q[3];
    assign busy = busy_q;
    assign done = done_q;
    assign step = step_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       i1, i2, i3, i4;
    logic       busy;
    logic       done;
    logic [3:0] step;

    int checks;
    int errors;

    // Event times in cycles after E for CYCLES_PER_TICK=2, and {i4,i3,i2,i1} after each event
    int         ev_time [13] = '{0, 10, 14, 16, 22, 32, 42, 52, 58, 64, 68, 72, 78};
    logic [3:0] ev_pat  [13] = '{4'b0100, 4'b0101, 4'b0001, 4'b1001, 4'b1000, 4'b1010,
                                 4'b1011, 4'b0011, 4'b0111, 4'b1111, 4'b1101, 4'b1100,
                                 4'b1000};

    seq_pattern_gen #(
        .CYCLES_PER_TICK(2),
        .HOLD_TICKS     (2),
        .CNT_W          (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .i4    (i4),
        .busy  (busy),
        .done  (done),
        .step  (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {i4, i3, i2, i1, busy, done, step};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] expected_at(input int t);
        int k;
        if (t == 82) return {4'b0000, 1'b0, 1'b1, 4'd0};
        if (t > 82)  return 10'd0;
        k = 0;
        for (int j = 0; j < 13; j++) begin
            if (ev_time[j] <= t) k = j;
        end
        return {ev_pat[k], 1'b1, 1'b0, 4'(k)};
    endfunction

    // Starts a run at edge E and checks every cycle up to E+83; start is re-pulsed at E+restart_at.
    task automatic run_trace(input string name, input int restart_at);
        start = 1'b1;
        tick();
        for (int t = 0; t <= 83; t++) begin
            check($sformatf("%s t=%0d", name, t), 32'(observed()), 32'(expected_at(t)));
            start = (t + 1 == restart_at);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        #1;
        check("reset asserted", 32'(observed()), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("idle c=%0d", c), 32'(observed()), 32'd0);
            tick();
        end

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort in idle", 32'(observed()), 32'd0);

        run_trace("full run", -1);

        run_trace("restart busy", 30);

        // start sampled on the done edge is ignored, accepted one cycle later
        run_trace("start at done", 82);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start after done", 32'(observed()), 32'({4'b0100, 1'b1, 1'b0, 4'd0}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort cleanup", 32'(observed()), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 19; t++) tick();
        check("pre-abort E+19", 32'(observed()), 32'({4'b1001, 1'b1, 1'b0, 4'd3}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort E+20", 32'(observed()), 32'd0);
        for (int c = 0; c < 70; c++) begin
            tick();
            check($sformatf("post-abort c=%0d", c), 32'(observed()), 32'd0);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 80; t++) tick();
        check("hold E+80", 32'(observed()), 32'({4'b1000, 1'b1, 1'b0, 4'd12}));
        #3;
        reset = 1'b1;
        #1;
        check("async reset mid-hold", 32'(observed()), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("post-reset c=%0d", c), 32'(observed()), 32'd0);
            tick();
        end
        run_trace("replay", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
